// File: rtl/word_serializer_if.sv
// word_serializer_if: word handshake in, byte/strobe bus out to the shift queue.
interface word_serializer_if;
  logic [31:0] WORD_IN;
  logic        WORD_VALID;
  logic        WORD_READY;
  logic [7:0]  DATAOUT;
  logic        ENA;
  logic        BUSY;
  logic        DONE;
  modport master (output WORD_IN, WORD_VALID, input WORD_READY, DATAOUT, ENA, BUSY, DONE);
  modport slave  (input WORD_IN, WORD_VALID, output WORD_READY, DATAOUT, ENA, BUSY, DONE);
endinterface

// File: rtl/word_serializer.sv
// word_serializer: sends a 32-bit word MSB-first as four ENA-strobed bytes with guaranteed low gaps.
module word_serializer #(
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 1
) (
  input logic               CLK,
  input logic               RST_N,
  word_serializer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t      state, state_nx;
  logic [31:0] sh;
  logic [1:0]  idx;
  logic [7:0]  cnt;
  logic        done;
  logic        hold_end, gap_end;
  assign hold_end = cnt == 8'(HOLD_CYCLES - 1);
  assign gap_end  = cnt == 8'(GAP_CYCLES - 1);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (bus.WORD_VALID ? HIGH : IDLE) :
               state == HIGH ? (hold_end ? LOW : HIGH) :
               gap_end       ? (idx == 2'd3 ? IDLE : HIGH) : LOW;
  // sh[31:24] doubles as the DATAOUT register, so it holds the last byte while idle
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      sh   <= '0;
      idx  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= state == LOW && gap_end && idx == 2'd3;
      if (state == IDLE) begin
        if (bus.WORD_VALID) begin
          sh  <= bus.WORD_IN;
          idx <= '0;
          cnt <= '0;
        end
      end else if (state == HIGH) begin
        cnt <= hold_end ? 8'd0 : cnt + 8'd1;
      end else if (gap_end) begin
        cnt <= '0;
        if (idx != 2'd3) begin
          sh  <= sh << 8;
          idx <= idx + 2'd1;
        end
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  always_comb begin
    bus.ENA        = state == HIGH;
    bus.BUSY       = state != IDLE;
    bus.WORD_READY = state == IDLE;
    bus.DATAOUT    = sh[31:24];
    bus.DONE       = done;
  end
endmodule

// File: doc/word_serializer.md
# word_serializer

Upstream feeder for the 4×8-bit shift queue. It accepts a 32-bit word over a valid/ready handshake and emits it as four bytes, most-significant byte first, on an 8-bit `DATAOUT` bus. Each byte is qualified by a single `ENA` pulse, and every pulse is followed by a guaranteed low gap. The queue captures on rising `ENA` edges, so after one word its 32-bit output equals the word that was sent.

## Interface
- `HOLD_CYCLES`, default 1: cycles `ENA` stays high per byte. Legal range 1..255.
- `GAP_CYCLES`, default 1: cycles `ENA` stays low after each byte. Legal range 1..255; must be ≥1 so the next rising edge is visible.

- `CLK`  in  1  single clock; all logic on rising edge.
- `RST_N`  in  1  reset, asynchronous and active-low.
- `WORD_IN`  in  32  word to send; sampled only on handshake.
- `WORD_VALID`  in  1  `WORD_IN` is valid.
- `WORD_READY`  out  1  block can accept a word; high exactly in IDLE.
- `DATAOUT`  out  8  current byte, to the queue's `DATAIN`.
- `ENA`  out  1  byte strobe, to the queue's `ENA`.
- `BUSY`  out  1  high in any state other than IDLE.
- `DONE`  out  1  one-cycle pulse after the fourth byte's gap completes.

## Operation
- Datapath:
  - 32-bit shift register `sh`.
  - 2-bit byte index `idx`.
  - 8-bit phase counter `cnt`.
- All outputs are registered, or decoded from registered state only.
- FSM states:
  - IDLE:
    - `WORD_READY`=1, `ENA`=0.
    - On `WORD_VALID`&&`WORD_READY`: `sh`<=`WORD_IN`, `DATAOUT`<=`WORD_IN[31:24]`, `idx`<=0, `cnt`<=0, go to HIGH.
  - HIGH:
    - `ENA`=1 and `DATAOUT` held stable.
    - When `cnt`==`HOLD_CYCLES`-1: `cnt`<=0, go to LOW. Otherwise increment `cnt`.
  - LOW:
    - `ENA`=0 and `DATAOUT` held (it does not change during the gap).
    - When `cnt`==`GAP_CYCLES`-1 and `idx`==3: go to IDLE and set `DONE`=1 for the next cycle.
    - When `cnt`==`GAP_CYCLES`-1 and `idx`<3: `sh`<=`sh`<<8, `DATAOUT`<=`sh[23:16]`, `idx`++, `cnt`<=0, go to HIGH.
    - Otherwise increment `cnt`.
- Byte order on `DATAOUT`: `WORD_IN[31:24]`, then `[23:16]`, `[15:8]`, `[7:0]`.
- Handshake rules:
  - `WORD_VALID` asserted outside IDLE is ignored.
  - Changes to `WORD_IN` after acceptance have no effect.
  - `WORD_VALID` may drop or change at any time without protocol error.
- `DATAOUT` keeps the last sent byte while in IDLE.
- Reset (`RST_N`=0, at any time including mid-word):
  - Immediate, asynchronous.
  - State=IDLE; `sh`, `idx`, `cnt` = 0.
  - `DATAOUT`=8'h00, `ENA`=0, `DONE`=0, `BUSY`=0, `WORD_READY`=1.
  - Any partial word is dropped. No `DONE` is produced for it.

## Timing
- Handshake accepted at rising edge k. `ENA` is first high in cycle k+1.
- Each byte occupies `HOLD_CYCLES`+`GAP_CYCLES` cycles.
- `DONE` and `WORD_READY` are both high in cycle k+1+4·(`HOLD_CYCLES`+`GAP_CYCLES`).
- A new word may be accepted in that same cycle, so the minimum word period is 4·(H+G)+1 cycles. With defaults that is 9.
- `ENA` is never high for more than `HOLD_CYCLES` consecutive cycles.
- `ENA` is low for at least `GAP_CYCLES` cycles between pulses, including across word boundaries.
- The queue shifts once per `ENA` pulse. Its 32-bit output equals the sent word from the cycle after the fourth `ENA`-high cycle.

## Test plan
- Reset release, then `WORD_IN`=32'hA1B2C3D4 with `WORD_VALID` for one cycle, defaults (H=1, G=1):
  - `ENA` pattern 1,0,1,0,1,0,1,0.
  - `DATAOUT` A1, A1, B2, B2, C3, C3, D4, D4.
  - `DONE` high in the 9th cycle after acceptance.
  - Queue output 32'hA1B2C3D4.
- `HOLD_CYCLES`=3, `GAP_CYCLES`=2, word 32'h01020304:
  - Each byte shows `ENA` high for exactly 3 cycles, then low for 2.
  - `DONE` arrives 21 cycles after acceptance.
- `WORD_VALID` held high continuously with a new `WORD_IN` every cycle:
  - Only words present in IDLE cycles are accepted.
  - Back-to-back words are spaced 9 cycles.
  - `WORD_READY` is low throughout each transfer.
- `RST_N` pulled low during the second byte's HIGH phase:
  - `ENA` and `DATAOUT` go to 0 asynchronously, without waiting for a clock edge.
  - No `DONE` is produced.
  - After release, the next word sends cleanly starting from its MSB.
- `WORD_IN` changed to 32'hFFFFFFFF one cycle after accepting 32'h12345678:
  - Bytes 12, 34, 56, 78 are emitted unchanged.
- After `DONE`, idle for 5 cycles:
  - `DATAOUT` stays 8'h78.
  - `ENA`=0, `BUSY`=0, `WORD_READY`=1.
